// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_pkg
// Description : Shared definitions for the clock-enable / reset sequencer.
//               Holds the sequencer state encoding and the default values of
//               the configuration parameters used by clk_rst_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_rst_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_DIV_W      = 8;
   localparam int DEF_RST_CYCLES = 16;
   localparam int DEF_STAGGER    = 2;
   localparam int DEF_CNT_W      = 32;

endpackage : clk_rst_pkg
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_div
// Description : Single-channel clock-enable divider. While act_i is high it
//               emits a one-cycle pulse every div+1 cycles, the first pulse
//               landing in the first active cycle. The divide value is
//               captured only at a pulse, so a new div_i value never
//               shortens the period in progress.
// Ports       : clk    - clock
//               rst    - synchronous active-high reset
//               act_i  - channel will be active in the next cycle
//               div_i  - divide value (period = div_i + 1)
//               en_o   - registered enable pulse
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_div
   import clk_rst_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             act_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             en_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             en_q,  en_d;

   // While inactive both the count and the latched divide value sit at zero,
   // so the first active cycle sees cnt_q == div_q and starts a period.
   always_comb begin
      cnt_d = cnt_q;
      div_d = div_q;
      en_d  = 1'b0;
      if (!act_i) begin
         cnt_d = '0;
         div_d = '0;
      end else if (cnt_q == div_q) begin
         en_d  = 1'b1;
         cnt_d = '0;
         div_d = div_i;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         div_q <= '0;
         en_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
         en_q  <= en_d;
      end
   end

   assign en_o = en_q;

endmodule : clk_en_div
`default_nettype wire

// File: rtl/clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_ctrl
// Description : Derived reset / clock-enable sequencer. Holds all channel
//               resets for RST_CYCLES, releases them one by one STAGGER
//               cycles apart, then runs a cycle counter with an optional
//               timeout. Each channel gets a divided clock-enable pulse.
// Ports       : clk           - single clock
//               rst           - synchronous active-high reset
//               soft_rst_req  - rerun the reset sequence
//               div_i         - per-channel divide values, DIV_W bits each
//               timeout_lim_i - RUN cycle limit, 0 disables
//               ch_rst_o      - per-channel reset, active-high
//               ch_en_o       - per-channel clock-enable pulse
//               rst_done_o    - all channels released and running
//               cycle_cnt_o   - cycles spent in RUN (saturating)
//               timeout_o     - sticky timeout flag (cleared by rst only)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_ctrl
   import clk_rst_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DIV_W      = DEF_DIV_W,
   parameter int RST_CYCLES = DEF_RST_CYCLES,
   parameter int STAGGER    = DEF_STAGGER,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    soft_rst_req,
   input  logic [NUM_CH*DIV_W-1:0] div_i,
   input  logic [CNT_W-1:0]        timeout_lim_i,
   output logic [NUM_CH-1:0]       ch_rst_o,
   output logic [NUM_CH-1:0]       ch_en_o,
   output logic                    rst_done_o,
   output logic [CNT_W-1:0]        cycle_cnt_o,
   output logic                    timeout_o
);

   localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
   localparam int REL_MAX = (NUM_CH - 1) * STAGGER;
   localparam int REL_W   = $clog2(REL_MAX + 2);

   state_e              state_q,     state_d;
   logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
   logic [REL_W-1:0]    rel_cnt_q,   rel_cnt_d;
   logic [NUM_CH-1:0]   ch_rst_q,    ch_rst_d;
   logic                rst_done_q,  rst_done_d;
   logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
   logic                timeout_q,   timeout_d;
   logic [NUM_CH-1:0]   ch_act_d;
   logic [NUM_CH-1:0]   ch_en_w;

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      ch_rst_d    = ch_rst_q;
      cycle_cnt_d = cycle_cnt_q;
      timeout_d   = timeout_q;
      rst_done_d  = 1'b0;
      ch_act_d    = '0;

      if (soft_rst_req) begin
         // Restart the whole sequence; the timeout flag stays sticky.
         state_d     = ST_HOLD;
         hold_cnt_d  = '0;
         rel_cnt_d   = '0;
         ch_rst_d    = '1;
         cycle_cnt_d = '0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                  state_d    = ST_RELEASE;
                  hold_cnt_d = '0;
                  rel_cnt_d  = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (rel_cnt_q == REL_W'(REL_MAX)) begin
                  state_d     = ST_RUN;
                  cycle_cnt_d = '0;
               end else begin
                  rel_cnt_d = rel_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if ((timeout_lim_i != '0) && (cycle_cnt_q == timeout_lim_i)) begin
                  state_d   = ST_TIMEOUT;
                  timeout_d = 1'b1;
               end else if (cycle_cnt_q != '1) begin
                  cycle_cnt_d = cycle_cnt_q + 1'b1;
               end
            end
            ST_TIMEOUT: begin
               // Frozen until rst or soft_rst_req.
            end
            default: begin
               state_d = ST_HOLD;
            end
         endcase

         // Channel k leaves reset once the release count reaches k*STAGGER;
         // evaluated on the next count so the output stays registered.
         if (state_d == ST_RELEASE) begin
            for (int k = 0; k < NUM_CH; k++) begin
               ch_rst_d[k] = (rel_cnt_d < REL_W'(k * STAGGER));
            end
         end
      end

      rst_done_d = (state_d == ST_RUN);

      // Dividers run only for released channels outside HOLD/TIMEOUT.
      for (int k = 0; k < NUM_CH; k++) begin
         ch_act_d[k] = !ch_rst_d[k] &&
                       ((state_d == ST_RELEASE) || (state_d == ST_RUN));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_HOLD;
         hold_cnt_q  <= '0;
         rel_cnt_q   <= '0;
         ch_rst_q    <= '1;
         rst_done_q  <= 1'b0;
         cycle_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         ch_rst_q    <= ch_rst_d;
         rst_done_q  <= rst_done_d;
         cycle_cnt_q <= cycle_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_div
      clk_en_div #(
         .DIV_W (DIV_W)
      ) u_div (
         .clk   (clk),
         .rst   (rst),
         .act_i (ch_act_d[g]),
         .div_i (div_i[g*DIV_W +: DIV_W]),
         .en_o  (ch_en_w[g])
      );
   end

   assign ch_rst_o    = ch_rst_q;
   assign ch_en_o     = ch_en_w;
   assign rst_done_o  = rst_done_q;
   assign cycle_cnt_o = cycle_cnt_q;
   assign timeout_o   = timeout_q;

endmodule : clk_rst_ctrl
`default_nettype wire

// File: tb/tb_clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_rst_ctrl
// Description : Self-checking bench for clk_rst_ctrl at default parameters.
//               Start-up sequence from a table, then hand sequences for
//               divide change, soft reset, timeout and rst priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rst_ctrl;

   logic        clk;
   logic        rst;
   logic        soft_rst_req;
   logic [31:0] div_i;
   logic [31:0] timeout_lim_i;
   logic [3:0]  ch_rst_o;
   logic [3:0]  ch_en_o;
   logic        rst_done_o;
   logic [31:0] cycle_cnt_o;
   logic        timeout_o;

   typedef struct packed {
      logic [3:0]  ch_rst;
      logic [3:0]  ch_en;
      logic        done;
      logic [31:0] cnt;
      logic        to;
   } outs_t;

   typedef struct {
      string name;
      int    t;
      outs_t exp;
   } vec_t;

   outs_t exp_q[$];
   vec_t  tbl[15];
   int    n_vec = 0;
   int    n_err = 0;
   int    cur   = 0;

   clk_rst_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .soft_rst_req  (soft_rst_req),
      .div_i         (div_i),
      .timeout_lim_i (timeout_lim_i),
      .ch_rst_o      (ch_rst_o),
      .ch_en_o       (ch_en_o),
      .rst_done_o    (rst_done_o),
      .cycle_cnt_o   (cycle_cnt_o),
      .timeout_o     (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic outs_t mk(input logic [3:0] r, input logic [3:0] e,
                                input logic d, input logic [31:0] c, input logic t);
      outs_t o;
      o.ch_rst = r;
      o.ch_en  = e;
      o.done   = d;
      o.cnt    = c;
      o.to     = t;
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @t=%0d: got %0h, expected %0h", name, cur, act, exp);
      end
   endtask

   // Expected outputs are queued before the clock is advanced and popped
   // once the DUT has produced the corresponding cycle.
   task automatic run_chk(input string name, input int n, input outs_t exp);
      outs_t act;
      outs_t want;
      exp_q.push_back(exp);
      repeat (n) tick();
      want = exp_q.pop_front();
      act  = mk(ch_rst_o, ch_en_o, rst_done_o, cycle_cnt_o, timeout_o);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s @t=%0d: got rst=%b en=%b done=%b cnt=%0d to=%b, expected rst=%b en=%b done=%b cnt=%0d to=%b",
                  name, cur, act.ch_rst, act.ch_en, act.done, act.cnt, act.to,
                  want.ch_rst, want.ch_en, want.done, want.cnt, want.to);
      end
   endtask

   initial begin
      // div: ch0=0, ch1=3, ch2=1, ch3=2
      tbl[0]  = '{"reset_state",  0, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0)};
      tbl[1]  = '{"hold_1",       1, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0)};
      tbl[2]  = '{"hold_last",   15, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0)};
      tbl[3]  = '{"rel0",        16, mk(4'b1110, 4'b0001, 1'b0, 32'd0, 1'b0)};
      tbl[4]  = '{"rel1",        17, mk(4'b1110, 4'b0001, 1'b0, 32'd0, 1'b0)};
      tbl[5]  = '{"rel2",        18, mk(4'b1100, 4'b0011, 1'b0, 32'd0, 1'b0)};
      tbl[6]  = '{"rel3",        19, mk(4'b1100, 4'b0001, 1'b0, 32'd0, 1'b0)};
      tbl[7]  = '{"rel4",        20, mk(4'b1000, 4'b0101, 1'b0, 32'd0, 1'b0)};
      tbl[8]  = '{"rel5",        21, mk(4'b1000, 4'b0001, 1'b0, 32'd0, 1'b0)};
      tbl[9]  = '{"rel6",        22, mk(4'b0000, 4'b1111, 1'b0, 32'd0, 1'b0)};
      tbl[10] = '{"run0",        23, mk(4'b0000, 4'b0001, 1'b1, 32'd0, 1'b0)};
      tbl[11] = '{"run1",        24, mk(4'b0000, 4'b0101, 1'b1, 32'd1, 1'b0)};
      tbl[12] = '{"run2",        25, mk(4'b0000, 4'b1001, 1'b1, 32'd2, 1'b0)};
      tbl[13] = '{"run3",        26, mk(4'b0000, 4'b0111, 1'b1, 32'd3, 1'b0)};
      tbl[14] = '{"run5",        28, mk(4'b0000, 4'b1101, 1'b1, 32'd5, 1'b0)};

      rst           = 1'b1;
      soft_rst_req  = 1'b0;
      div_i         = {8'd2, 8'd1, 8'd3, 8'd0};
      timeout_lim_i = 32'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cur = 0;

      // Start-up sequence and divided enables.
      for (int i = 0; i < 15; i++) begin
         run_chk(tbl[i].name, tbl[i].t - cur, tbl[i].exp);
      end

      // Divide change mid-period: ch1 3 -> 1 after its pulse at t30.
      repeat (2) tick();
      check_val("ch1_pulse_t30", {31'd0, ch_en_o[1]}, 32'd1);
      tick();
      div_i[15:8] = 8'd1;
      for (int t = 32; t <= 38; t++) begin
         logic [31:0] want;
         tick();
         want = (t == 34 || t == 36 || t == 38) ? 32'd1 : 32'd0;
         check_val($sformatf("ch1_divchg_t%0d", t), {31'd0, ch_en_o[1]}, want);
      end

      // Soft reset from RUN, then again mid-RELEASE after ch1 released.
      soft_rst_req = 1'b1;
      run_chk("soft_from_run", 1, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0));
      soft_rst_req = 1'b0;
      run_chk("soft_hold_last", 15, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0));
      run_chk("soft_rel0",       1, mk(4'b1110, 4'b0001, 1'b0, 32'd0, 1'b0));
      run_chk("soft_rel2",       2, mk(4'b1100, 4'b0011, 1'b0, 32'd0, 1'b0));
      soft_rst_req = 1'b1;
      run_chk("soft_mid_rel",    1, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0));
      soft_rst_req = 1'b0;
      run_chk("rehold_last",    15, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0));
      run_chk("rehold_rel0",     1, mk(4'b1110, 4'b0001, 1'b0, 32'd0, 1'b0));

      // Timeout at 10 RUN cycles; sticky across soft reset.
      timeout_lim_i = 32'd10;
      run_chk("to_run0",   7, mk(4'b0000, 4'b0001, 1'b1, 32'd0,  1'b0));
      run_chk("to_cnt10", 10, mk(4'b0000, 4'b0001, 1'b1, 32'd10, 1'b0));
      run_chk("to_enter",  1, mk(4'b0000, 4'b0000, 1'b0, 32'd10, 1'b1));
      run_chk("to_frozen", 3, mk(4'b0000, 4'b0000, 1'b0, 32'd10, 1'b1));
      soft_rst_req = 1'b1;
      run_chk("to_soft",   1, mk(4'b1111, 4'b0000, 1'b0, 32'd0,  1'b1));
      soft_rst_req = 1'b0;
      run_chk("to_soft_rel0", 16, mk(4'b1110, 4'b0001, 1'b0, 32'd0, 1'b1));
      run_chk("to_soft_run0",  7, mk(4'b0000, 4'b0001, 1'b1, 32'd0, 1'b1));
      run_chk("to_soft_run3",  3, mk(4'b0000, 4'b0111, 1'b1, 32'd3, 1'b1));

      // rst together with soft_rst_req in RUN behaves as rst alone.
      timeout_lim_i = 32'd0;
      div_i[31:24]  = 8'd255;
      rst           = 1'b1;
      soft_rst_req  = 1'b1;
      run_chk("rst_soft",  1, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0));
      rst           = 1'b0;
      soft_rst_req  = 1'b0;
      cur           = 0;
      run_chk("rs_hold_last", 15, mk(4'b1111, 4'b0000, 1'b0, 32'd0, 1'b0));
      run_chk("rs_rel0",       1, mk(4'b1110, 4'b0001, 1'b0, 32'd0, 1'b0));
      run_chk("rs_rel6",       6, mk(4'b0000, 4'b1111, 1'b0, 32'd0, 1'b0));

      // ch3 divide 255: next pulse exactly 256 cycles after the first.
      run_chk("div255_t277", 255, mk(4'b0000, 4'b0001, 1'b1, 32'd254, 1'b0));
      run_chk("div255_t278",   1, mk(4'b0000, 4'b1111, 1'b1, 32'd255, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_clk_rst_ctrl
`default_nettype wire

// File: doc/clk_rst_ctrl.md
CLK_RST_CTRL -- requirements
Module: clk_rst_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of derived channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8: width of each channel divide value.
REQ-003 SHALL have parameter RST_CYCLES, default 16: hold length of reset for all channels (>=1).
REQ-004 SHALL have parameter STAGGER, default 2: cycles between successive channel reset releases (>=1).
REQ-005 SHALL have parameter CNT_W, default 32: width of cycle counter and timeout limit.
REQ-006 SHALL have port clk  input  1  single clock for all logic.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port soft_rst_req  input  1  single-cycle request to rerun the reset sequence.
REQ-009 SHALL have port div_i  input  NUM_CH*DIV_W  per-channel divide value; channel k occupies bits [k*DIV_W +: DIV_W].
REQ-010 SHALL have port timeout_lim_i  input  CNT_W  run-cycle limit; 0 disables timeout.
REQ-011 SHALL have port ch_rst_o  output  NUM_CH  per-channel synchronous reset, active-high.
REQ-012 SHALL have port ch_en_o  output  NUM_CH  per-channel clock-enable pulse.
REQ-013 SHALL have port rst_done_o  output  1  high while all channels are released and running.
REQ-014 SHALL have port cycle_cnt_o  output  CNT_W  cycles spent in RUN since last release.
REQ-015 SHALL have port timeout_o  output  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM states HOLD, RELEASE, RUN, TIMEOUT, with reset state HOLD.
REQ-017 HOLD: all ch_rst_o=1, ch_en_o=0; leave for RELEASE after exactly RST_CYCLES cycles in HOLD.
REQ-018 RELEASE: deassert ch_rst_o[0] on the first RELEASE cycle, then ch_rst_o[k] STAGGER cycles after ch_rst_o[k-1]; enter RUN on the cycle after the last channel is released.
REQ-019 RUN: rst_done_o=1; cycle_cnt_o increments by 1 per cycle and saturates at all-ones (no wrap).
REQ-020 RUN -> TIMEOUT when timeout_lim_i != 0 and cycle_cnt_o == timeout_lim_i; TIMEOUT forces ch_en_o=0, rst_done_o=0, timeout_o=1, channels stay out of reset, cycle_cnt_o frozen.
REQ-021 TIMEOUT is left only via rst or soft_rst_req; timeout_o clears only on rst (sticky across soft_rst_req).
REQ-022 soft_rst_req=1 in any state SHALL move the FSM to HOLD on the next cycle, restarting the RST_CYCLES count, clearing cycle_cnt_o and divider counters; a request during HOLD restarts the count.
REQ-023 Each channel SHALL have a divider counter active only while its ch_rst_o=0; ch_en_o[k] pulses for one cycle every div_i[k]+1 cycles, first pulse on the first cycle after release.
REQ-024 div_i[k]=0 SHALL give ch_en_o[k]=1 on every enabled cycle; div_i[k]=all-ones gives period 2^DIV_W.
REQ-025 A change of div_i[k] SHALL take effect only at the channel's next pulse (period boundary); no glitch or truncated period.
REQ-026 ch_en_o SHALL be 0 in HOLD and TIMEOUT and for any channel still held in reset.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 On rst=1 at a clk edge: state=HOLD, ch_rst_o=all-ones, ch_en_o=0, rst_done_o=0, cycle_cnt_o=0, timeout_o=0, all internal counters 0.
REQ-029 rst SHALL take priority over soft_rst_req and all other events in the same cycle.

Structure
REQ-030 FSM state enum and default parameter constants SHALL live in shared package clk_rst_pkg.
REQ-031 The per-channel divider SHALL be sub-module clk_en_div (one DIV_W counter, pulse output, boundary-latched divide value), instantiated NUM_CH times by generate.
REQ-032 The block SHALL be synthesisable and instantiable in the bench top in place of the free-running clock toggle for derived enables and resets.

Verification
REQ-033 Defaults, rst for 1 cycle: ch_rst_o=4'b1111 for 16 cycles, then bits release at RELEASE cycles 0,2,4,6; rst_done_o=1 one cycle after bit 3 clears.
REQ-034 div_i ch0=0, ch1=3: in RUN ch_en_o[0] high every cycle, ch_en_o[1] high every 4th cycle starting first cycle after its release.
REQ-035 timeout_lim_i=10: cycle_cnt_o reaches 10, next cycle timeout_o=1, ch_en_o=0; soft_rst_req then reruns sequence with timeout_o still 1; rst clears it.
REQ-036 soft_rst_req asserted mid-RELEASE (after ch1 released): all ch_rst_o return to 1 next cycle, full 16-cycle HOLD restarts.
REQ-037 Change ch1 div_i from 3 to 1 mid-period: current 4-cycle period completes, then period 2.
REQ-038 rst and soft_rst_req asserted together in RUN: response identical to rst alone, timeout_o=0.
